// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction ROM between the fetch (F)
// and data-load (D) requesters. Round-robin arbitration, one registered
// response slot per port, one cycle from acceptance to response.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. Requesters must not make valid depend on
// ready. The arbiter's req_ready may depend on req_valid.

module rom_arbiter #(
    parameter int XLEN      = 32,
    parameter int ROM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_data,

    input  logic            f_req_valid,
    output logic            f_req_ready,
    input  logic [XLEN-1:0] f_req_addr,
    output logic            f_rsp_valid,
    input  logic            f_rsp_ready,
    output logic [XLEN-1:0] f_rsp_data,
    output logic            f_rsp_err,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    output logic            d_rsp_valid,
    input  logic            d_rsp_ready,
    output logic [XLEN-1:0] d_rsp_data,
    output logic            d_rsp_err
);

    // Full-width limit so high addresses never wrap into the ROM range.
    localparam logic [XLEN-1:0] LP_ROM_LIMIT = XLEN'(ROM_BYTES);

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    gnt_t            r_last_gnt;

    logic            r_f_rsp_valid;
    logic [XLEN-1:0] r_f_rsp_data;
    logic            r_f_rsp_err;
    logic            r_d_rsp_valid;
    logic [XLEN-1:0] r_d_rsp_data;
    logic            r_d_rsp_err;

    logic            w_f_elig;
    logic            w_d_elig;
    logic            w_gnt_f;
    logic            w_gnt_d;
    logic [XLEN-1:0] w_gnt_addr;
    logic            w_err;

    // A port is eligible only if its slot is free or being drained this cycle.
    assign w_f_elig = f_req_valid && (!r_f_rsp_valid || f_rsp_ready);
    assign w_d_elig = d_req_valid && (!r_d_rsp_valid || d_rsp_ready);

    // Round-robin: on contention the port that did not win last time wins.
    // Nothing is accepted while reset is held.
    assign w_gnt_f = rst_n && w_f_elig && (!w_d_elig || (r_last_gnt == GNT_D));
    assign w_gnt_d = rst_n && w_d_elig && (!w_f_elig || (r_last_gnt == GNT_F));

    assign f_req_ready = w_gnt_f;
    assign d_req_ready = w_gnt_d;

    // Address of the winning port (zero when nobody is granted).
    always_comb begin
        w_gnt_addr = '0;
        if (w_gnt_f) begin
            w_gnt_addr = f_req_addr;
        end else if (w_gnt_d) begin
            w_gnt_addr = d_req_addr;
        end
    end

    assign rom_addr = {w_gnt_addr[XLEN-1:2], 2'b00};

    // Misaligned or out-of-range accesses still consume the grant and slot.
    assign w_err = (w_gnt_addr[1:0] != 2'b00) || (w_gnt_addr >= LP_ROM_LIMIT);

    // Fairness pointer: moves only when a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= GNT_D;
        end else if (w_gnt_f) begin
            r_last_gnt <= GNT_F;
        end else if (w_gnt_d) begin
            r_last_gnt <= GNT_D;
        end
    end

    // F response slot: load on grant (replacing a draining entry), else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_rsp_valid <= 1'b0;
            r_f_rsp_data  <= '0;
            r_f_rsp_err   <= 1'b0;
        end else if (w_gnt_f) begin
            r_f_rsp_valid <= 1'b1;
            r_f_rsp_err   <= w_err;
            r_f_rsp_data  <= w_err ? '0 : rom_data;
        end else if (r_f_rsp_valid && f_rsp_ready) begin
            r_f_rsp_valid <= 1'b0;
        end
    end

    // D response slot: load on grant (replacing a draining entry), else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
            r_d_rsp_err   <= 1'b0;
        end else if (w_gnt_d) begin
            r_d_rsp_valid <= 1'b1;
            r_d_rsp_err   <= w_err;
            r_d_rsp_data  <= w_err ? '0 : rom_data;
        end else if (r_d_rsp_valid && d_rsp_ready) begin
            r_d_rsp_valid <= 1'b0;
        end
    end

    assign f_rsp_valid = r_f_rsp_valid;
    assign f_rsp_data  = r_f_rsp_data;
    assign f_rsp_err   = r_f_rsp_err;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rsp_data  = r_d_rsp_data;
    assign d_rsp_err   = r_d_rsp_err;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: per-cycle vector table for grant/rom_addr, response
// scoreboard per port, plus a hand-written asynchronous mid-cycle reset.

module tb_rom_arbiter;

    localparam int XLEN = 32;
    localparam int ROM_BYTES = 1024;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_data;
    logic            f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
    logic [XLEN-1:0] f_req_addr, f_rsp_data;
    logic            d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [XLEN-1:0] d_req_addr, d_rsp_data;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 0;

    // {err, data}
    logic [XLEN:0] f_exp_q[$];
    logic [XLEN:0] d_exp_q[$];

    rom_arbiter #(.XLEN(XLEN), .ROM_BYTES(ROM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
        .f_rsp_err(f_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .d_rsp_err(d_rsp_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    function automatic logic [XLEN-1:0] rom_word(input logic [XLEN-1:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        case (idx)
            8'd0:    return 32'h00a54533;
            8'd1:    return 32'h0052c2b3;
            8'd7:    return 32'h00000063;
            default: return (32'h9E3779B1 * {24'd0, idx}) ^ 32'h13579bdf;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    function automatic logic [XLEN:0] exp_rsp(input logic [XLEN-1:0] a);
        logic e;
        e = (a[1:0] != 2'b00) || (a >= 32'(ROM_BYTES));
        return {e, e ? 32'h0 : rom_word({a[XLEN-1:2], 2'b00})};
    endfunction

    task automatic chk(input string nm, input logic [XLEN:0] act, input logic [XLEN:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // At each falling edge: compare the visible response with the queue head,
    // pop on consume, then push the expectation for any request being accepted.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("f_rsp_valid_in_reset", {32'h0, f_rsp_valid}, 33'h0);
                chk("d_rsp_valid_in_reset", {32'h0, d_rsp_valid}, 33'h0);
                f_exp_q.delete();
                d_exp_q.delete();
            end else begin
                chk("f_rsp_valid", {32'h0, f_rsp_valid}, {32'h0, f_exp_q.size() != 0});
                if (f_exp_q.size() != 0) begin
                    chk("f_rsp", {f_rsp_err, f_rsp_data}, f_exp_q[0]);
                    if (f_rsp_ready) void'(f_exp_q.pop_front());
                end
                chk("d_rsp_valid", {32'h0, d_rsp_valid}, {32'h0, d_exp_q.size() != 0});
                if (d_exp_q.size() != 0) begin
                    chk("d_rsp", {d_rsp_err, d_rsp_data}, d_exp_q[0]);
                    if (d_rsp_ready) void'(d_exp_q.pop_front());
                end
                if (f_req_ready) f_exp_q.push_back(exp_rsp(f_req_addr));
                if (d_req_ready) d_exp_q.push_back(exp_rsp(d_req_addr));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit              do_rst;
        bit              fv;
        logic [XLEN-1:0] fa;
        bit              fr;
        bit              dv;
        logic [XLEN-1:0] da;
        bit              dr;
        bit              ef;   // expected f_req_ready
        bit              ed;   // expected d_req_ready
        logic [XLEN-1:0] ea;   // expected rom_addr
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rs, bit fv, logic [XLEN-1:0] fa, bit fr,
                                bit dv, logic [XLEN-1:0] da, bit dr,
                                bit ef, bit ed, logic [XLEN-1:0] ea);
        vec_t v;
        v.do_rst = rs; v.fv = fv; v.fa = fa; v.fr = fr;
        v.dv = dv; v.da = da; v.dr = dr; v.ef = ef; v.ed = ed; v.ea = ea;
        return v;
    endfunction

    task automatic drive_idle();
        f_req_valid = 0; f_req_addr = '0; f_rsp_ready = 1;
        d_req_valid = 0; d_req_addr = '0; d_rsp_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.do_rst) do_reset();
        @(posedge clk);
        #1;
        f_req_valid = v.fv; f_req_addr = v.fa; f_rsp_ready = v.fr;
        d_req_valid = v.dv; d_req_addr = v.da; d_rsp_ready = v.dr;
        @(negedge clk);
        chk($sformatf("f_req_ready[%0d]", idx), {32'h0, f_req_ready}, {32'h0, v.ef});
        chk($sformatf("d_req_ready[%0d]", idx), {32'h0, d_req_ready}, {32'h0, v.ed});
        chk($sformatf("rom_addr[%0d]", idx), {1'b0, rom_addr}, {1'b0, v.ea});
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        #1;
        chk("reset_f_rsp", {f_rsp_err, f_rsp_data}, 33'h0);
        chk("reset_d_rsp", {d_rsp_err, d_rsp_data}, 33'h0);
        chk("reset_valids", {31'h0, f_rsp_valid, d_rsp_valid}, 33'h0);
        mon_en = 1;

        //             rst fv fa            fr dv da          dr ef ed ea
        // Lone F back-to-back.
        vecs.push_back(mk(1, 1, 32'h0,        1, 0, 32'h0,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h4,        1, 0, 32'h0,     1, 1, 0, 32'h4));
        vecs.push_back(mk(0, 1, 32'h1c,       1, 0, 32'h0,     1, 1, 0, 32'h1c));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,     1, 0, 0, 32'h0));
        // Saturating contention from reset: F first, then alternate.
        vecs.push_back(mk(1, 1, 32'h0,        1, 1, 32'h4,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0,        1, 1, 32'h4,     1, 0, 1, 32'h4));
        vecs.push_back(mk(0, 1, 32'h0,        1, 1, 32'h4,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0,        1, 1, 32'h4,     1, 0, 1, 32'h4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,     1, 0, 0, 32'h0));
        // Error addresses still alternate fairly (last grant was D).
        vecs.push_back(mk(0, 1, 32'h2,        1, 1, 32'h8,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h400,      1, 1, 32'h8,     1, 0, 1, 32'h8));
        vecs.push_back(mk(0, 1, 32'h400,      1, 1, 32'h8,     1, 1, 0, 32'h400));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 1, 32'h3FC,   1, 0, 1, 32'h3FC));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 1, 32'h3FC,   1, 1, 0, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,     1, 0, 0, 32'h0));
        // D slot filled and stalled; F granted every cycle.
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,     0, 0, 1, 32'h4));
        vecs.push_back(mk(0, 1, 32'h8,        1, 1, 32'h4,     0, 1, 0, 32'h8));
        vecs.push_back(mk(0, 1, 32'hc,        1, 1, 32'h4,     0, 1, 0, 32'hc));
        vecs.push_back(mk(0, 1, 32'h10,       1, 1, 32'h4,     0, 1, 0, 32'h10));
        // D second request waits, then is accepted in the drain cycle.
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,     0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,     1, 0, 1, 32'h4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,     1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,     1, 0, 0, 32'h0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Mid-cycle asynchronous reset with both slots holding responses.
        apply(mk(1, 1, 32'h0, 0, 1, 32'h4, 0, 1, 0, 32'h0), 100);
        apply(mk(0, 1, 32'h0, 0, 1, 32'h4, 0, 0, 1, 32'h4), 101);
        @(posedge clk);
        #3;
        drive_idle();
        rst_n = 0;
        #1;
        chk("async_rst_valids", {31'h0, f_rsp_valid, d_rsp_valid}, 33'h0);
        chk("async_rst_f_rsp", {f_rsp_err, f_rsp_data}, 33'h0);
        chk("async_rst_d_rsp", {d_rsp_err, d_rsp_data}, 33'h0);
        f_req_valid = 1; d_req_valid = 1;
        #0.1;
        chk("ready_in_reset", {31'h0, f_req_ready, d_req_ready}, 33'h0);
        f_req_valid = 0; d_req_valid = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        // First contention after reset goes to F.
        apply(mk(0, 1, 32'h1c, 1, 1, 32'h0, 1, 1, 0, 32'h1c), 102);
        apply(mk(0, 1, 32'h1c, 1, 1, 32'h0, 1, 0, 1, 32'h0), 103);
        apply(mk(0, 0, 32'h0,  1, 0, 32'h0, 1, 0, 0, 32'h0), 104);
        apply(mk(0, 0, 32'h0,  1, 0, 32'h0, 1, 0, 0, 32'h0), 105);

        chk("f_q_empty", {1'b0, 32'(f_exp_q.size())}, 33'h0);
        chk("d_q_empty", {1'b0, 32'(d_exp_q.size())}, 33'h0);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
